// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline.
// Drives stage enables and bubble injects from memory handshakes, load-use and redirects.
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_data_valid,
    input  logic             d_data_valid,
    input  logic             ex_mem_access,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_redirect,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       ctrl_state,
    output logic             err_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] TMO    = WCW'(TIMEOUT);
    localparam logic [WCW-1:0] TMO_M1 = WCW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_IWAIT = 2'd1,
        S_DWAIT = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        A_GO,
        A_DSTALL,
        A_REDIR,
        A_LDUSE,
        A_ISTALL,
        A_IHOLD,
        A_DHOLD
    } act_t;

    state_t r_state;
    state_t w_state_nxt;
    state_t w_run_nxt;
    act_t   w_act;
    act_t   w_run_act;

    logic [WCW-1:0]   r_wcnt;
    logic             r_err;
    logic [CNT_W-1:0] r_stall;
    logic [CNT_W-1:0] r_flush;

    logic w_dstall;
    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_ldu;
    logic w_wait_entry;
    logic w_wait_hold;

    logic w_pc_en;
    logic w_ifid_en;
    logic w_idex_en;
    logic w_exmem_en;
    logic w_memwb_en;
    logic w_ifid_flush;
    logic w_idex_flush;

    assign w_dstall  = ex_mem_access & ~d_data_valid;
    assign w_rs1_hit = id_use_rs1 & (id_rs1 == ex_rd);
    assign w_rs2_hit = id_use_rs2 & (id_rs2 == ex_rd);
    assign w_ldu     = ex_mem_read & (ex_rd != 5'd0)
                     & (w_rs1_hit | w_rs2_hit);

    // RUN priority; FLUSH ignores load-use because ID holds a NOP
    always_comb begin
        w_run_act = A_GO;
        w_run_nxt = S_RUN;
        if (w_dstall) begin
            w_run_act = A_DSTALL;
            w_run_nxt = S_DWAIT;
        end else if (ex_redirect) begin
            w_run_act = A_REDIR;
            w_run_nxt = S_FLUSH;
        end else if (w_ldu && (r_state != S_FLUSH)) begin
            w_run_act = A_LDUSE;
            w_run_nxt = S_RUN;
        end else if (!i_data_valid) begin
            w_run_act = A_ISTALL;
            w_run_nxt = S_IWAIT;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_act       = w_run_act;
        w_state_nxt = w_run_nxt;
        unique case (r_state)
            S_IWAIT: begin
                if (!w_dstall && !ex_redirect) begin
                    if (i_data_valid) begin
                        w_act       = A_GO;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_act       = A_IHOLD;
                        w_state_nxt = S_IWAIT;
                    end
                end
            end
            S_DWAIT: begin
                if (!d_data_valid) begin
                    w_act       = A_DHOLD;
                    w_state_nxt = S_DWAIT;
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        w_pc_en      = 1'b0;
        w_ifid_en    = 1'b0;
        w_idex_en    = 1'b0;
        w_exmem_en   = 1'b0;
        w_memwb_en   = 1'b0;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;
        unique case (w_act)
            A_GO: begin
                w_pc_en    = 1'b1;
                w_ifid_en  = 1'b1;
                w_idex_en  = 1'b1;
                w_exmem_en = 1'b1;
                w_memwb_en = 1'b1;
            end
            A_REDIR: begin
                w_pc_en      = 1'b1;
                w_ifid_en    = 1'b1;
                w_idex_en    = 1'b1;
                w_exmem_en   = 1'b1;
                w_memwb_en   = 1'b1;
                w_ifid_flush = 1'b1;
                w_idex_flush = 1'b1;
            end
            A_LDUSE: begin
                w_idex_en    = 1'b1;
                w_exmem_en   = 1'b1;
                w_memwb_en   = 1'b1;
                w_idex_flush = 1'b1;
            end
            A_ISTALL, A_IHOLD: begin
                w_ifid_en    = 1'b1;
                w_idex_en    = 1'b1;
                w_exmem_en   = 1'b1;
                w_memwb_en   = 1'b1;
                w_ifid_flush = 1'b1;
            end
            default: begin
            end
        endcase
        // squash the word fetched from the pre-redirect PC
        if ((r_state == S_FLUSH) && (w_act != A_DSTALL)) begin
            w_ifid_flush = 1'b1;
        end
        if (!reset_n) begin
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_en    = 1'b0;
            w_exmem_en   = 1'b0;
            w_memwb_en   = 1'b0;
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
        end
    end

    assign w_wait_entry = ((w_state_nxt == S_IWAIT) || (w_state_nxt == S_DWAIT))
                        && (w_state_nxt != r_state);
    assign w_wait_hold  = (w_act == A_IHOLD) || (w_act == A_DHOLD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wcnt <= '0;
            r_err  <= 1'b0;
        end else if (w_wait_entry) begin
            r_wcnt <= '0;
        end else if (w_wait_hold) begin
            if (r_wcnt != TMO) begin
                r_wcnt <= r_wcnt + 1'b1;
            end
            if (r_wcnt >= TMO_M1) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall <= '0;
            r_flush <= '0;
        end else begin
            if (!w_pc_en && (r_stall != '1)) begin
                r_stall <= r_stall + 1'b1;
            end
            if ((w_act == A_REDIR) && (r_flush != '1)) begin
                r_flush <= r_flush + 1'b1;
            end
        end
    end

    assign pc_en        = w_pc_en;
    assign ifid_en      = w_ifid_en;
    assign idex_en      = w_idex_en;
    assign exmem_en     = w_exmem_en;
    assign memwb_en     = w_memwb_en;
    assign ifid_flush   = w_ifid_flush;
    assign idex_flush   = w_idex_flush;
    assign ctrl_state   = r_state;
    assign err_timeout  = r_err;
    assign stall_cycles = r_stall;
    assign flush_count  = r_flush;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table through a scoreboard queue,
// plus timeout and async-reset sequences.
module tb_pipeline_hazard_ctrl;

    localparam int TMO = 255;
    localparam int CW  = 16;

    // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
    localparam logic [6:0] EN_ALL  = 7'b11111_00;
    localparam logic [6:0] EN_NONE = 7'b00000_00;
    localparam logic [6:0] REDIR   = 7'b11111_11;
    localparam logic [6:0] LDU     = 7'b00111_01;
    localparam logic [6:0] IST     = 7'b01111_10;
    localparam logic [6:0] FL_RUN  = 7'b11111_10;
    localparam logic [6:0] IN_RST  = 7'b00000_11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          i_data_valid, d_data_valid;
    logic          ex_mem_access, ex_mem_read;
    logic [4:0]    ex_rd, id_rs1, id_rs2;
    logic          id_use_rs1, id_use_rs2, ex_redirect;
    logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic          ifid_flush, idex_flush;
    logic [1:0]    ctrl_state;
    logic          err_timeout;
    logic [CW-1:0] stall_cycles, flush_count;

    pipeline_hazard_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .i_data_valid(i_data_valid),
        .d_data_valid(d_data_valid),
        .ex_mem_access(ex_mem_access),
        .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd),
        .id_rs1(id_rs1),
        .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2),
        .ex_redirect(ex_redirect),
        .pc_en(pc_en),
        .ifid_en(ifid_en),
        .idex_en(idex_en),
        .exmem_en(exmem_en),
        .memwb_en(memwb_en),
        .ifid_flush(ifid_flush),
        .idex_flush(idex_flush),
        .ctrl_state(ctrl_state),
        .err_timeout(err_timeout),
        .stall_cycles(stall_cycles),
        .flush_count(flush_count)
    );

    wire [6:0] w_out = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                        ifid_flush, idex_flush};

    typedef struct {
        logic       iv, dv, acc, rdm;
        logic [4:0] rd, rs1, rs2;
        logic       u1, u2, rdr;
        logic [6:0] en;
        logic [1:0] st;
    } vec_t;

    typedef struct {
        logic [6:0] en;
        logic [1:0] st;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[37];
    int   checks = 0;
    int   errors = 0;
    int   m_stall = 0;
    int   m_flush = 0;

    function automatic vec_t mk(input logic iv, input logic dv,
                                input logic acc, input logic rdm,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic u1, input logic [4:0] rs2,
                                input logic u2, input logic rdr,
                                input logic [6:0] en, input logic [1:0] st);
        vec_t v;
        v.iv = iv; v.dv = dv; v.acc = acc; v.rdm = rdm;
        v.rd = rd; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.rdr = rdr; v.en = en; v.st = st;
        return v;
    endfunction

    function automatic vec_t nom(input logic [6:0] en, input logic [1:0] st);
        return mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, en, st);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        i_data_valid  = v.iv;
        d_data_valid  = v.dv;
        ex_mem_access = v.acc;
        ex_mem_read   = v.rdm;
        ex_rd         = v.rd;
        id_rs1        = v.rs1;
        id_use_rs1    = v.u1;
        id_rs2        = v.rs2;
        id_use_rs2    = v.u2;
        ex_redirect   = v.rdr;
    endtask

    task automatic step(input vec_t v, input string nm);
        exp_t e;
        exp_t g;
        @(posedge clk);
        #1;
        drive(v);
        e.en = v.en;
        e.st = v.st;
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() == 0) begin
            chk({nm, " sb_empty"}, 32'd0, 32'd1);
        end else begin
            g = sb.pop_front();
            chk({nm, " en"}, 32'(w_out), 32'(g.en));
            chk({nm, " state"}, 32'(ctrl_state), 32'(g.st));
        end
    endtask

    task automatic chk_cnt(input string nm);
        chk({nm, " stall_cycles"}, 32'(stall_cycles), 32'(m_stall));
        chk({nm, " flush_count"}, 32'(flush_count), 32'(m_flush));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = nom(EN_ALL, 0);
        tbl[1]  = mk(1, 1, 1, 1, 5, 5, 1, 1, 1, 0, LDU, 0);
        tbl[2]  = nom(EN_ALL, 0);
        tbl[3]  = mk(1, 1, 1, 1, 0, 0, 1, 0, 1, 0, EN_ALL, 0);
        tbl[4]  = mk(1, 1, 1, 1, 7, 3, 1, 7, 0, 0, EN_ALL, 0);
        tbl[5]  = mk(1, 1, 1, 1, 7, 3, 1, 7, 1, 0, LDU, 0);
        tbl[6]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, REDIR, 0);
        tbl[7]  = nom(FL_RUN, 3);
        tbl[8]  = nom(EN_ALL, 0);
        tbl[9]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, REDIR, 0);
        tbl[10] = mk(1, 1, 1, 1, 5, 5, 1, 0, 0, 0, FL_RUN, 3);
        tbl[11] = nom(EN_ALL, 0);
        tbl[12] = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, EN_NONE, 0);
        tbl[13] = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, EN_NONE, 2);
        tbl[14] = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, EN_NONE, 2);
        tbl[15] = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, EN_ALL, 2);
        tbl[16] = nom(EN_ALL, 0);
        tbl[17] = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, EN_NONE, 0);
        tbl[18] = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, EN_NONE, 2);
        tbl[19] = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, REDIR, 2);
        tbl[20] = nom(FL_RUN, 3);
        tbl[21] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, IST, 0);
        tbl[22] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, IST, 1);
        tbl[23] = nom(EN_ALL, 1);
        tbl[24] = nom(EN_ALL, 0);
        tbl[25] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, IST, 0);
        tbl[26] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, REDIR, 1);
        tbl[27] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, IST, 3);
        tbl[28] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, EN_NONE, 1);
        tbl[29] = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, EN_ALL, 2);
        tbl[30] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, REDIR, 0);
        tbl[31] = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, EN_NONE, 3);
        tbl[32] = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, EN_ALL, 2);
        tbl[33] = nom(EN_ALL, 0);
        tbl[34] = mk(1, 0, 1, 1, 5, 5, 1, 0, 0, 0, EN_NONE, 0);
        tbl[35] = mk(1, 1, 1, 1, 5, 5, 1, 0, 0, 0, LDU, 2);
        tbl[36] = nom(EN_ALL, 0);

        reset_n = 1'b0;
        drive(nom(EN_ALL, 0));
        @(negedge clk);
        @(negedge clk);
        chk("reset en", 32'(w_out), 32'(IN_RST));
        chk("reset state", 32'(ctrl_state), 32'd0);
        chk("reset err", 32'(err_timeout), 32'd0);
        chk_cnt("reset");
        reset_n = 1'b1;

        for (int i = 0; i < 37; i++) begin
            step(tbl[i], $sformatf("row%0d", i));
            chk_cnt($sformatf("row%0d", i));
            if (tbl[i].en[6] == 1'b0) m_stall++;
            if (tbl[i].en == REDIR) m_flush++;
        end
        chk("table err", 32'(err_timeout), 32'd0);

        // instruction ROM silent long enough to trip the timeout
        for (int c = 0; c < 300; c++) begin
            step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, IST, (c == 0) ? 2'd0 : 2'd1),
                 $sformatf("tmo%0d", c));
            if (c == 255) chk("tmo err before", 32'(err_timeout), 32'd0);
            if (c == 256) chk("tmo err set", 32'(err_timeout), 32'd1);
            if (c == 299) chk("tmo err held", 32'(err_timeout), 32'd1);
            m_stall++;
        end
        step(nom(EN_ALL, 1), "tmo exit");
        step(nom(EN_ALL, 0), "tmo run");
        chk("tmo sticky", 32'(err_timeout), 32'd1);
        chk_cnt("tmo");

        // asynchronous reset in the middle of a data wait
        step(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, EN_NONE, 0), "ar0");
        step(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, EN_NONE, 2), "ar1");
        step(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, EN_NONE, 2), "ar2");
        #2;
        reset_n = 1'b0;
        #1;
        m_stall = 0;
        m_flush = 0;
        chk("async state", 32'(ctrl_state), 32'd0);
        chk("async err", 32'(err_timeout), 32'd0);
        chk("async en", 32'(w_out), 32'(IN_RST));
        chk_cnt("async");
        @(negedge clk);
        chk("hold state", 32'(ctrl_state), 32'd0);
        drive(nom(EN_ALL, 0));
        reset_n = 1'b1;
        step(nom(EN_ALL, 0), "post reset");
        chk_cnt("post reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
